// File: rtl/game_pkg.sv
// Shared constants for the memory-game datapath.
package game_pkg;

  localparam int unsigned SEQ_LEN  = 7;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned LIVES_W  = 2;
  localparam int unsigned DIV_W    = 5;
  localparam int unsigned LEVEL_W  = 5;
  localparam int unsigned DIGIT_W  = 2;
  localparam int unsigned LFSR_W   = 8;

  localparam int unsigned INIT_DIV = 25;
  localparam logic [LIVES_W-1:0] INIT_LIVES = LIVES_W'(3);
  localparam logic [LEVEL_W-1:0] INIT_LEVEL = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] MAX_LEVEL  = LEVEL_W'(31);
  localparam logic [LFSR_W-1:0]  LFSR_SEED  = 8'hA5;

endpackage

// File: rtl/game_lfsr.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running from a nonzero seed.
module game_lfsr
  import game_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] q
);

  // Shift left, feedback from taps 8,6,5,4; nonzero seed keeps it out of the lockup state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= LFSR_SEED;
    else        q <= {q[LFSR_W-2:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule

// File: rtl/game_datapath.sv
// Memory-game datapath: counters, sequence/user RAMs, compare, and show/blank phase timers.
module game_datapath
  import game_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 500000,
  parameter int unsigned BLANK_TICKS = 10,
  parameter int unsigned INIT_DIV    = game_pkg::INIT_DIV
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init_seq_counter,
  input  logic               init_user_counter,
  input  logic               init_match_counter,
  input  logic               init_show_counter,
  input  logic               init_lives,
  input  logic               init_level,
  input  logic               reset_clk,
  input  logic               incr_seq_counter,
  input  logic               incr_user_counter,
  input  logic               incr_level,
  input  logic               decr_show_counter,
  input  logic               decr_lives,
  input  logic               decr_clk,
  input  logic               store_num,
  input  logic               store_input,
  input  logic               read_seq,
  input  logic               read_input,
  input  logic               show_ready,
  input  logic               blank_ready,
  input  logic [DIGIT_W-1:0] keyVal,
  output logic               seq_end,
  output logic               full_input,
  output logic               end_comp,
  output logic               match,
  output logic               show_counter_zero,
  output logic               no_lives,
  output logic               clk_zero,
  output logic               goBlank,
  output logic               goShow,
  output logic [DIGIT_W-1:0] seq_num,
  output logic [LEVEL_W-1:0] level,
  output logic [LIVES_W-1:0] lives
);

  localparam int unsigned PRE_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned BLANK_W = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(SEQ_LEN);

  logic [CNT_W-1:0]   seq_cnt, user_cnt, match_cnt;
  logic               show_cnt;
  logic [DIV_W-1:0]   div;
  logic [DIGIT_W-1:0] seq_ram  [0:SEQ_LEN-1];
  logic [DIGIT_W-1:0] user_ram [0:SEQ_LEN-1];
  logic [LFSR_W-1:0]  lfsr_q;
  logic [PRE_W-1:0]   presc;
  logic [DIV_W-1:0]   show_tmr;
  logic [BLANK_W-1:0] blank_tmr;

  logic               seq_valid_c, user_valid_c, tick_c, digit_eq_c;
  logic [DIGIT_W-1:0] seq_dig_c, user_dig_c;
  logic               unused_lfsr_c;

  game_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  // Only the low digit bits of the LFSR feed the sequence
  assign unused_lfsr_c = ^lfsr_q[LFSR_W-1:DIGIT_W];

  // Pointer-qualified RAM reads; index SEQ_LEN means "past the end" and reads 0
  assign seq_valid_c  = (seq_cnt  != CNT_END);
  assign user_valid_c = (user_cnt != CNT_END);
  assign seq_dig_c    = seq_valid_c  ? seq_ram[seq_cnt]   : '0;
  assign user_dig_c   = user_valid_c ? user_ram[user_cnt] : '0;
  assign digit_eq_c   = (seq_dig_c == user_dig_c);
  assign tick_c       = (presc == PRE_W'(TICK_CYCLES - 1));

  // Status decodes
  assign seq_end           = (seq_cnt == CNT_END);
  assign full_input        = (user_cnt == CNT_END);
  assign match             = (match_cnt == CNT_END);
  assign end_comp          = read_input & seq_end;
  assign show_counter_zero = (show_cnt == 1'b0);
  assign no_lives          = (lives == '0);
  assign clk_zero          = (div == '0);
  assign seq_num           = read_seq ? seq_dig_c : '0;

  // Sequence and user pointers; init beats incr, increments saturate
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_cnt  <= '0;
      user_cnt <= '0;
    end else begin
      if (init_seq_counter)                  seq_cnt <= '0;
      else if (incr_seq_counter && !seq_end) seq_cnt <= seq_cnt + CNT_W'(1);
      if (init_user_counter)                     user_cnt <= '0;
      else if (incr_user_counter && !full_input) user_cnt <= user_cnt + CNT_W'(1);
    end
  end

  // Match counter advances on each equal digit pair seen during a compare read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                              match_cnt <= '0;
    else if (init_match_counter)                             match_cnt <= '0;
    else if (read_input && seq_valid_c && digit_eq_c && !match) match_cnt <= match_cnt + CNT_W'(1);
  end

  // Show counter, lives, level and speed divider
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      show_cnt <= 1'b1;
      lives    <= INIT_LIVES;
      level    <= INIT_LEVEL;
      div      <= DIV_W'(INIT_DIV);
    end else begin
      if (init_show_counter)      show_cnt <= 1'b1;
      else if (decr_show_counter) show_cnt <= 1'b0;
      if (init_lives)                    lives <= INIT_LIVES;
      else if (decr_lives && !no_lives)  lives <= lives - LIVES_W'(1);
      if (init_level)                           level <= INIT_LEVEL;
      else if (incr_level && level != MAX_LEVEL) level <= level + LEVEL_W'(1);
      if (reset_clk)                   div <= DIV_W'(INIT_DIV);
      else if (decr_clk && !clk_zero)  div <= div - DIV_W'(1);
    end
  end

  // Digit RAMs; writes at the past-the-end pointer are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SEQ_LEN; i++) begin
        seq_ram[i]  <= '0;
        user_ram[i] <= '0;
      end
    end else begin
      if (store_num && seq_valid_c)    seq_ram[seq_cnt]   <= lfsr_q[DIGIT_W-1:0];
      if (store_input && user_valid_c) user_ram[user_cnt] <= keyVal;
    end
  end

  // Free-running base-tick prescaler
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      presc <= '0;
    else if (tick_c) presc <= '0;
    else             presc <= presc + PRE_W'(1);
  end

  // Show timer: goBlank after div+1 ticks of an exclusive show phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      show_tmr <= '0;
      goBlank  <= 1'b0;
    end else begin
      goBlank <= 1'b0;
      if (!show_ready || blank_ready) begin
        show_tmr <= '0;
      end else if (tick_c) begin
        if (show_tmr >= div) begin
          show_tmr <= '0;
          goBlank  <= 1'b1;
        end else begin
          show_tmr <= show_tmr + DIV_W'(1);
        end
      end
    end
  end

  // Blank timer: goShow after BLANK_TICKS ticks of an exclusive blank phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blank_tmr <= '0;
      goShow    <= 1'b0;
    end else begin
      goShow <= 1'b0;
      if (!blank_ready || show_ready) begin
        blank_tmr <= '0;
      end else if (tick_c) begin
        if (blank_tmr >= BLANK_W'(BLANK_TICKS - 1)) begin
          blank_tmr <= '0;
          goShow    <= 1'b1;
        end else begin
          blank_tmr <= blank_tmr + BLANK_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_game_datapath.sv
// Self-checking bench for game_datapath: per-cycle model comparison plus directed literal checks.
module tb_game_datapath;
  localparam int TICK  = 4;
  localparam int BLANK = 10;
  localparam int IDIV  = 25;

  logic clk = 1'b0;
  logic reset;
  logic init_seq_counter, init_user_counter, init_match_counter, init_show_counter;
  logic init_lives, init_level, reset_clk;
  logic incr_seq_counter, incr_user_counter, incr_level, decr_show_counter, decr_lives, decr_clk;
  logic store_num, store_input, read_seq, read_input, show_ready, blank_ready;
  logic [1:0] keyVal;
  logic seq_end, full_input, end_comp, match, show_counter_zero, no_lives, clk_zero;
  logic goBlank, goShow;
  logic [1:0] seq_num;
  logic [4:0] level;
  logic [1:0] lives;

  int pass_cnt = 0;
  int total_cnt = 0;

  game_datapath #(.TICK_CYCLES(TICK), .BLANK_TICKS(BLANK), .INIT_DIV(IDIV)) dut (
    .clk(clk), .reset(reset),
    .init_seq_counter(init_seq_counter), .init_user_counter(init_user_counter),
    .init_match_counter(init_match_counter), .init_show_counter(init_show_counter),
    .init_lives(init_lives), .init_level(init_level), .reset_clk(reset_clk),
    .incr_seq_counter(incr_seq_counter), .incr_user_counter(incr_user_counter),
    .incr_level(incr_level), .decr_show_counter(decr_show_counter),
    .decr_lives(decr_lives), .decr_clk(decr_clk),
    .store_num(store_num), .store_input(store_input),
    .read_seq(read_seq), .read_input(read_input),
    .show_ready(show_ready), .blank_ready(blank_ready), .keyVal(keyVal),
    .seq_end(seq_end), .full_input(full_input), .end_comp(end_comp), .match(match),
    .show_counter_zero(show_counter_zero), .no_lives(no_lives), .clk_zero(clk_zero),
    .goBlank(goBlank), .goShow(goShow), .seq_num(seq_num), .level(level), .lives(lives)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_seq, m_user, m_match, m_show, m_lives, m_level, m_div, m_cyc, m_st, m_bt;
  int m_sram[7];
  int m_uram[7];
  bit m_gb, m_gs, m_tick;
  int m_sd, m_ud;
  logic [7:0] m_lfsr;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_seq = 0; m_user = 0; m_match = 0; m_show = 1; m_lives = 3; m_level = 1;
      m_div = IDIV; m_cyc = 0; m_st = 0; m_bt = 0; m_gb = 0; m_gs = 0;
      m_lfsr = 8'hA5;
      for (int i = 0; i < 7; i++) begin m_sram[i] = 0; m_uram[i] = 0; end
    end else begin
      m_tick = (m_cyc % TICK) == TICK - 1;
      m_cyc++;
      // compare on pre-edge contents
      m_sd = (m_seq < 7) ? m_sram[m_seq] : 0;
      m_ud = (m_user < 7) ? m_uram[m_user] : 0;
      if (read_input && m_seq < 7 && m_sd == m_ud && m_match < 7) m_match++;
      if (init_match_counter) m_match = 0;
      // memory writes
      if (store_num && m_seq < 7) m_sram[m_seq] = int'(m_lfsr[1:0]);
      if (store_input && m_user < 7) m_uram[m_user] = int'(keyVal);
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
      // phase timers, tick counts against the pre-edge divider
      m_gb = 0; m_gs = 0;
      if (show_ready && !blank_ready) begin
        if (m_tick) begin
          m_st++;
          if (m_st == m_div + 1) begin m_gb = 1; m_st = 0; end
        end
      end else m_st = 0;
      if (blank_ready && !show_ready) begin
        if (m_tick) begin
          m_bt++;
          if (m_bt == BLANK) begin m_gs = 1; m_bt = 0; end
        end
      end else m_bt = 0;
      // counters: step with saturation, then init overrides
      if (incr_seq_counter && m_seq < 7) m_seq++;
      if (init_seq_counter) m_seq = 0;
      if (incr_user_counter && m_user < 7) m_user++;
      if (init_user_counter) m_user = 0;
      if (decr_show_counter) m_show = 0;
      if (init_show_counter) m_show = 1;
      if (decr_lives && m_lives > 0) m_lives--;
      if (init_lives) m_lives = 3;
      if (incr_level && m_level < 31) m_level++;
      if (init_level) m_level = 1;
      if (decr_clk && m_div > 0) m_div--;
      if (reset_clk) m_div = IDIV;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (reset) begin
      chk("seq_end", int'(seq_end), int'(m_seq == 7));
      chk("full_input", int'(full_input), int'(m_user == 7));
      chk("end_comp", int'(end_comp), int'(read_input && m_seq == 7));
      chk("match", int'(match), int'(m_match == 7));
      chk("show_counter_zero", int'(show_counter_zero), int'(m_show == 0));
      chk("no_lives", int'(no_lives), int'(m_lives == 0));
      chk("clk_zero", int'(clk_zero), int'(m_div == 0));
      chk("goBlank", int'(goBlank), int'(m_gb));
      chk("goShow", int'(goShow), int'(m_gs));
      chk("seq_num", int'(seq_num), (read_seq && m_seq < 7) ? m_sram[m_seq] : 0);
      chk("level", int'(level), m_level);
      chk("lives", int'(lives), m_lives);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
    {init_seq_counter, init_user_counter, init_match_counter, init_show_counter,
     init_lives, init_level, reset_clk, incr_seq_counter, incr_user_counter, incr_level,
     decr_show_counter, decr_lives, decr_clk, store_num, store_input, read_input} = '0;
  endtask

  int exp_d[3] = '{1, 2, 1};
  int pulses;

  initial begin
    reset = 1'b0;
    {init_seq_counter, init_user_counter, init_match_counter, init_show_counter,
     init_lives, init_level, reset_clk, incr_seq_counter, incr_user_counter, incr_level,
     decr_show_counter, decr_lives, decr_clk, store_num, store_input, read_input} = '0;
    read_seq = 0; show_ready = 0; blank_ready = 0; keyVal = 0;
    repeat (3) @(negedge clk);
    chk("rst_seq_end", int'(seq_end), 0);
    chk("rst_lives", int'(lives), 3);
    chk("rst_level", int'(level), 1);
    chk("rst_show_zero", int'(show_counter_zero), 0);
    chk("rst_clk_zero", int'(clk_zero), 0);
    chk("rst_goBlank", int'(goBlank), 0);

    // fill the sequence RAM from the LFSR
    for (int i = 0; i < 7; i++) begin
      store_num = 1; incr_seq_counter = 1;
      if (i == 0) reset = 1'b1;
      step();
      if (i == 5) chk("seq_end_after6", int'(seq_end), 0);
    end
    chk("seq_end_after7", int'(seq_end), 1);
    store_num = 1; step();                 // dropped: pointer past end

    // read back the stored digits
    init_seq_counter = 1; step();
    read_seq = 1; #1;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) chk($sformatf("seq_digit%0d", i), int'(seq_num), exp_d[i]);
      incr_seq_counter = 1; step();
    end
    chk("seq_num_past_end", int'(seq_num), 0);
    read_seq = 0;

    // user digits equal to the sequence -> full match
    init_user_counter = 1; step();
    for (int i = 0; i < 7; i++) begin
      store_input = 1; keyVal = 2'(m_sram[i]); incr_user_counter = 1; step();
    end
    chk("full_input", int'(full_input), 1);
    store_input = 1; keyVal = 2'd3; step();   // dropped
    init_seq_counter = 1; init_user_counter = 1; init_match_counter = 1; step();
    for (int i = 0; i < 7; i++) begin
      read_input = 1; incr_seq_counter = 1; incr_user_counter = 1; step();
    end
    read_input = 1; #1;
    chk("end_comp_full", int'(end_comp), 1);
    chk("match_full", int'(match), 1);
    step();

    // one differing digit -> no match
    init_user_counter = 1; step();
    for (int i = 0; i < 7; i++) begin
      store_input = 1; keyVal = 2'((i == 3) ? (m_sram[i] + 1) % 4 : m_sram[i]);
      incr_user_counter = 1; step();
    end
    init_seq_counter = 1; init_user_counter = 1; init_match_counter = 1; step();
    for (int i = 0; i < 7; i++) begin
      read_input = 1; incr_seq_counter = 1; incr_user_counter = 1; step();
    end
    read_input = 1; #1;
    chk("end_comp_diff", int'(end_comp), 1);
    chk("match_diff", int'(match), 0);
    step();

    // level increments and saturation
    init_level = 1; step();
    repeat (3) begin incr_level = 1; step(); end
    chk("level_4", int'(level), 4);
    repeat (40) begin incr_level = 1; step(); end
    chk("level_sat", int'(level), 31);
    init_level = 1; incr_level = 1; step();
    chk("level_init_wins", int'(level), 1);

    // lives
    init_lives = 1; step();
    repeat (3) begin decr_lives = 1; step(); end
    chk("no_lives", int'(no_lives), 1);
    decr_lives = 1; step();
    chk("lives_floor", int'(lives), 0);
    init_lives = 1; decr_lives = 1; step();
    chk("lives_init_wins", int'(lives), 3);

    // show counter
    init_show_counter = 1; step();
    chk("show_cnt_one", int'(show_counter_zero), 0);
    repeat (2) begin decr_show_counter = 1; step(); end
    chk("show_cnt_zero", int'(show_counter_zero), 1);
    init_show_counter = 1; decr_show_counter = 1; step();
    chk("show_init_wins", int'(show_counter_zero), 0);

    // speed divider
    reset_clk = 1; step();
    repeat (24) begin decr_clk = 1; step(); end
    chk("clk_zero_24", int'(clk_zero), 0);
    decr_clk = 1; step();
    chk("clk_zero_25", int'(clk_zero), 1);
    repeat (2) begin decr_clk = 1; step(); end
    chk("clk_zero_floor", int'(clk_zero), 1);
    reset_clk = 1; decr_clk = 1; step();
    chk("clk_init_wins", int'(clk_zero), 0);

    // phase timers from a fresh reset with show_ready already held
    reset = 0; show_ready = 1; @(negedge clk);
    chk("rst_no_goBlank", int'(goBlank), 0);
    reset = 1;
    repeat (103) step();
    chk("goBlank_103", int'(goBlank), 0);
    step();
    chk("goBlank_104", int'(goBlank), 1);
    show_ready = 0; blank_ready = 1;
    step();
    chk("goBlank_one_cycle", int'(goBlank), 0);
    repeat (38) step();
    chk("goShow_143", int'(goShow), 0);
    step();
    chk("goShow_144", int'(goShow), 1);
    step();
    chk("goShow_one_cycle", int'(goShow), 0);

    // both phases at once: no pulses
    show_ready = 1; blank_ready = 1; pulses = 0;
    repeat (200) begin step(); pulses += int'(goBlank) + int'(goShow); end
    chk("both_ready_pulses", pulses, 0);

    // reset in the middle of a show phase abandons it
    blank_ready = 0;
    reset = 0; @(negedge clk); reset = 1;
    repeat (50) step();
    reset = 0; @(negedge clk); @(negedge clk); reset = 1;
    pulses = 0;
    repeat (103) begin step(); pulses += int'(goBlank); end
    chk("no_residual_goBlank", pulses, 0);
    step();
    chk("goBlank_after_rerun", int'(goBlank), 1);
    show_ready = 0;
    repeat (3) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
